// File: rtl/rasterint_gen.sv
// Z80 /INT generator for the vertical-retrace and programmed raster-line interrupts.
// Define ZXUNO_INTACK_EN to let an interrupt acknowledge (/IORQ and /M1 both low) end a pulse early.
module rasterint_gen #(
  parameter logic [8:0] VINT_LINE = 9'd248,
  parameter logic [8:0] INT_HC    = 9'd0,
  parameter logic [7:0] INT_LEN   = 8'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] hc,
  input  logic [8:0] vc,
  input  logic       rasterint_enable,
  input  logic       vretraceint_disable,
  input  logic [8:0] raster_line,
  input  logic       iorq_n,
  input  logic       m1_n,
  output logic       int_n,
  output logic       raster_int_in_progress
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE_VR = 2'd1,
    PULSE_RA = 2'd2
  } state_t;

  localparam logic [7:0] LOAD = INT_LEN - 8'd1;

  state_t     state, state_nx;
  logic [7:0] count, count_nx;
  logic       vr_hit, ra_hit, vr_hit_d, ra_hit_d;
  logic       vr_trig, ra_trig, ack;
  logic       int_n_nx, rip_nx;

  assign vr_hit = (vc == VINT_LINE) & (hc == INT_HC) & ~vretraceint_disable;
  assign ra_hit = (vc == raster_line) & (hc == INT_HC) & rasterint_enable;

  // Edge-qualified so counters stalled on a matching value fire only once.
  assign vr_trig = vr_hit & ~vr_hit_d;
  assign ra_trig = ra_hit & ~ra_hit_d;

`ifdef ZXUNO_INTACK_EN
  assign ack = ~iorq_n & ~m1_n;
`else
  logic unused_ack;
  assign unused_ack = iorq_n & m1_n;
  assign ack        = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      count                  <= 8'd0;
      vr_hit_d               <= 1'b0;
      ra_hit_d               <= 1'b0;
      int_n                  <= 1'b1;
      raster_int_in_progress <= 1'b0;
    end else begin
      state                  <= state_nx;
      count                  <= count_nx;
      vr_hit_d               <= vr_hit;
      ra_hit_d               <= ra_hit;
      int_n                  <= int_n_nx;
      raster_int_in_progress <= rip_nx;
    end
  end

  // NOTE: defaults at the top of each always_comb keep every path assigned, so no latches.
  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      IDLE: begin
        if (ra_trig) begin
          state_nx = PULSE_RA;
          count_nx = LOAD;
        end else if (vr_trig) begin
          state_nx = PULSE_VR;
          count_nx = LOAD;
        end
      end
      PULSE_VR, PULSE_RA: begin
        // Triggers are deliberately ignored here: no retrigger, no queueing.
        if (ack || count == 8'd0) begin
          state_nx = IDLE;
          count_nx = 8'd0;
        end else begin
          count_nx = count - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state and then registered, keeping /INT glitch-free.
  always_comb begin
    int_n_nx = 1'b1;
    rip_nx   = 1'b0;
    if (state_nx != IDLE) int_n_nx = 1'b0;
    if (state_nx == PULSE_RA) rip_nx = 1'b1;
  end

endmodule

// File: tb/tb_rasterint_gen.sv
// Randomized self-checking bench for rasterint_gen, using a pulse-window reference model.
// Honours ZXUNO_INTACK_EN when the same macro is defined for the bench build.
module tb_rasterint_gen;

  localparam logic [8:0] VINT_LINE = 9'd248;
  localparam logic [8:0] INT_HC    = 9'd0;
  localparam int         INT_LEN   = 64;
  localparam int         H_TOTAL   = 4;
  localparam int         V_TOTAL   = 312;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] hc, vc, raster_line;
  logic       rasterint_enable, vretraceint_disable;
  logic       iorq_n, m1_n;
  logic       int_n, raster_int_in_progress;

  rasterint_gen #(
    .VINT_LINE(VINT_LINE),
    .INT_HC   (INT_HC),
    .INT_LEN  (8'(INT_LEN))
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .hc                    (hc),
    .vc                    (vc),
    .rasterint_enable      (rasterint_enable),
    .vretraceint_disable   (vretraceint_disable),
    .raster_line           (raster_line),
    .iorq_n                (iorq_n),
    .m1_n                  (m1_n),
    .int_n                 (int_n),
    .raster_int_in_progress(raster_int_in_progress)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_bad = 0;
  longint cyc = 0;
  // Model: the pulse occupies cycles p_start..p_end inclusive; p_ra gives its type.
  longint p_start = -1;
  longint p_end   = -2;
  bit     p_ra = 1'b0;
  bit     prev_vr = 1'b0, prev_ra = 1'b0;
  int     low_cycles, ra_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_pulse(input longint c);
    return (c >= p_start) && (c <= p_end);
  endfunction

  // Inputs for cycle cyc are already stable; predict, clock, then compare cycle cyc+1.
  task automatic run_cycle();
    bit vr, ra, exp_low;
    vr = (vc == VINT_LINE) && (hc == INT_HC) && !vretraceint_disable;
    ra = (vc == raster_line) && (hc == INT_HC) && rasterint_enable;
    if (!in_pulse(cyc) && ((ra && !prev_ra) || (vr && !prev_vr))) begin
      p_start = cyc + 1;
      p_end   = cyc + INT_LEN;
      p_ra    = ra && !prev_ra;
    end
`ifdef ZXUNO_INTACK_EN
    else if (in_pulse(cyc) && !iorq_n && !m1_n) p_end = cyc;
`endif
    prev_vr = vr;
    prev_ra = ra;
    @(posedge clk);
    #1;
    cyc++;
    exp_low = in_pulse(cyc);
    check("int_n", 32'(int_n), 32'(!exp_low));
    check("raster_int_in_progress", 32'(raster_int_in_progress), 32'(exp_low && p_ra));
    if (!int_n) low_cycles++;
    if (raster_int_in_progress) ra_cycles++;
  endtask

  task automatic advance();
    if (hc == 9'(H_TOTAL - 1)) begin
      hc = 9'd0;
      vc = (vc == 9'(V_TOTAL - 1)) ? 9'd0 : vc + 9'd1;
    end else begin
      hc = hc + 9'd1;
    end
  endtask

  // Sweep n_cyc cycles; optionally acknowledge at pulse cycle 10 and randomly stall counters.
  task automatic sweep(input int n_cyc, input bit ack10, input bit rnd);
    for (int i = 0; i < n_cyc; i++) begin
      if (!(rnd && $urandom_range(0, 15) == 0)) advance();
      iorq_n = 1'b1;
      m1_n   = 1'b1;
      if (ack10 && cyc == p_start + 9) begin
        iorq_n = 1'b0;
        m1_n   = 1'b0;
      end
      if (rnd) begin
        if ($urandom_range(0, 59) == 0) begin
          iorq_n = 1'b0;
          m1_n   = 1'b0;
        end else begin
          iorq_n = 1'($urandom_range(0, 1));
          m1_n   = 1'($urandom_range(0, 1)) | ~iorq_n;
        end
        if ($urandom_range(0, 299) == 0) rasterint_enable = ~rasterint_enable;
        if ($urandom_range(0, 299) == 0) vretraceint_disable = ~vretraceint_disable;
        if ($urandom_range(0, 399) == 0) raster_line = 9'($urandom_range(0, V_TOTAL - 1));
      end
      run_cycle();
    end
  endtask

  task automatic start_frame();
    hc = 9'(H_TOTAL - 1);
    vc = 9'(V_TOTAL - 1);
    low_cycles = 0;
    ra_cycles  = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hc = 9'd0; vc = 9'd0; raster_line = 9'h1FF;
    rasterint_enable = 1'b0; vretraceint_disable = 1'b0;
    iorq_n = 1'b1; m1_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset int_n", 32'(int_n), 32'd1);
    check("reset rip", 32'(raster_int_in_progress), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Retrace only.
    start_frame();
    sweep(H_TOTAL * V_TOTAL, 1'b0, 1'b0);
    check("retrace low cycles", 32'(low_cycles), 32'(INT_LEN));
    check("retrace rip cycles", 32'(ra_cycles), 32'd0);

    // Raster line 100, retrace suppressed.
    rasterint_enable = 1'b1; vretraceint_disable = 1'b1; raster_line = 9'd100;
    start_frame();
    sweep(H_TOTAL * V_TOTAL, 1'b0, 1'b0);
    check("raster low cycles", 32'(low_cycles), 32'(INT_LEN));
    check("raster rip cycles", 32'(ra_cycles), 32'(INT_LEN));

    // Collision on line 248: one raster-type pulse.
    vretraceint_disable = 1'b0; raster_line = VINT_LINE;
    start_frame();
    sweep(H_TOTAL * V_TOTAL, 1'b0, 1'b0);
    check("collision low cycles", 32'(low_cycles), 32'(INT_LEN));
    check("collision rip cycles", 32'(ra_cycles), 32'(INT_LEN));

    // Counters stalled on the matching position for 10 cycles.
    low_cycles = 0; ra_cycles = 0;
    hc = INT_HC; vc = VINT_LINE - 9'd1;
    run_cycle();
    vc = VINT_LINE;
    for (int i = 0; i < 10; i++) run_cycle();
    sweep(3 * INT_LEN, 1'b0, 1'b0);
    check("stall low cycles", 32'(low_cycles), 32'(INT_LEN));

    // Unreachable raster line for two frames.
    vretraceint_disable = 1'b1; raster_line = 9'h1FF;
    start_frame();
    sweep(2 * H_TOTAL * V_TOTAL, 1'b0, 1'b0);
    check("unreachable low cycles", 32'(low_cycles), 32'd0);

    // Acknowledge at pulse cycle 10.
    raster_line = 9'd100;
    start_frame();
    sweep(H_TOTAL * V_TOTAL, 1'b1, 1'b0);
`ifdef ZXUNO_INTACK_EN
    check("ack low cycles", 32'(low_cycles), 32'd10);
`else
    check("ack low cycles", 32'(low_cycles), 32'(INT_LEN));
`endif

    // Reset asserted at pulse cycle 20.
    start_frame();
    while (!(cyc == p_start + 19) && cyc < 100000) begin
      advance();
      run_cycle();
    end
    check("reached pulse cycle 20", 32'(in_pulse(cyc)), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset int_n", 32'(int_n), 32'd1);
    check("async reset rip", 32'(raster_int_in_progress), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    check("held reset int_n", 32'(int_n), 32'd1);
    rst_n = 1'b1;
    p_start = -1; p_end = -2; prev_vr = 1'b0; prev_ra = 1'b0;
    low_cycles = 0;
    sweep(2 * INT_LEN, 1'b0, 1'b0);
    check("no resume after reset", 32'(low_cycles), 32'd0);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      rasterint_enable    = 1'($urandom_range(0, 1));
      vretraceint_disable = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       raster_line = 9'h1FF;
        1:       raster_line = VINT_LINE;
        default: raster_line = 9'($urandom_range(0, V_TOTAL - 1));
      endcase
      sweep(H_TOTAL * V_TOTAL, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
